// File: rtl/memseq_if.sv
// Request-side and memory-bus-side signal bundle for the memseq sequencer.
// The slave modport is the sequencer's view; master is the view of whoever
// drives requests and answers the bus (microcode side plus memory model).
interface memseq_if;
  // request interface
  logic        REQ;
  logic        WRITE;
  logic        WORD;
  logic        SEXT;
  logic [15:0] ADDR;
  logic [15:0] WDATA;
  logic        BUSY;
  logic        DONE;
  logic        ODDERR;
  logic        TMOERR;
  // external memory bus
  logic [15:0] MADDR;
  logic [15:0] MWDATA;
  logic [1:0]  MBE;
  logic        MRD;
  logic        MWR;
  logic        MACK;
  logic [15:0] MRDATA;
  // BBUS read-data gate controls
  logic [15:0] RDATA;
  logic        RD_WORD;
  logic        RD_RE;
  logic        RD_SEXT;

  modport slave (
    input  REQ, WRITE, WORD, SEXT, ADDR, WDATA, MACK, MRDATA,
    output BUSY, DONE, ODDERR, TMOERR, MADDR, MWDATA, MBE, MRD, MWR,
           RDATA, RD_WORD, RD_RE, RD_SEXT
  );

  modport master (
    output REQ, WRITE, WORD, SEXT, ADDR, WDATA, MACK, MRDATA,
    input  BUSY, DONE, ODDERR, TMOERR, MADDR, MWDATA, MBE, MRD, MWR,
           RDATA, RD_WORD, RD_RE, RD_SEXT
  );
endinterface

// File: rtl/memseq.sv
// Memory access sequencer: takes one byte/word read or write from the
// microcode side, runs it on the external bus with a MACK timeout, aligns
// byte read data onto the low lane and drives the BBUS read-gate controls.
// Every output is a flop; the combinational block computes next values.
module memseq #(
  parameter int TMO_CYCLES = 255,
  parameter int TMO_W      = 8
) (
  input logic     CLOCK,
  input logic     RESET_N,
  memseq_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  // Last strobe cycle index before a timeout is declared.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);

  state_t            state_q, state_d;
  logic [TMO_W-1:0]  cnt_q, cnt_d;
  logic              word_q, word_d;
  logic              sext_q, sext_d;
  logic              lane_q, lane_d;   // latched ADDR[0]: selects the byte lane
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              odderr_q, odderr_d;
  logic              tmoerr_q, tmoerr_d;
  logic [15:0]       maddr_q, maddr_d;
  logic [15:0]       mwdata_q, mwdata_d;
  logic [1:0]        mbe_q, mbe_d;
  logic              mrd_q, mrd_d;
  logic              mwr_q, mwr_d;
  logic [15:0]       rdata_q, rdata_d;
  logic              rd_word_q, rd_word_d;
  logic              rd_re_q, rd_re_d;
  logic              rd_sext_q, rd_sext_d;

  // Next-state and next-output logic; pulses default low, data holds.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    sext_d    = sext_q;
    lane_d    = lane_q;
    maddr_d   = maddr_q;
    mwdata_d  = mwdata_q;
    mbe_d     = mbe_q;
    rdata_d   = rdata_q;
    done_d    = 1'b0;
    odderr_d  = 1'b0;
    tmoerr_d  = 1'b0;
    mrd_d     = 1'b0;
    mwr_d     = 1'b0;
    rd_word_d = 1'b0;
    rd_re_d   = 1'b0;
    rd_sext_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.REQ) begin
          word_d = bus.WORD;
          sext_d = bus.SEXT;
          lane_d = bus.ADDR[0];
          cnt_d  = '0;
          if (bus.WORD && bus.ADDR[0]) begin
            // Misaligned word: report straight away, never touch the bus.
            state_d  = ST_FIN;
            done_d   = 1'b1;
            odderr_d = 1'b1;
          end else begin
            maddr_d = {bus.ADDR[15:1], 1'b0};
            if (bus.WORD) begin
              mbe_d    = 2'b11;
              mwdata_d = bus.WDATA;
            end else begin
              mbe_d    = bus.ADDR[0] ? 2'b10 : 2'b01;
              mwdata_d = {bus.WDATA[7:0], bus.WDATA[7:0]};
            end
            if (bus.WRITE) begin
              state_d = ST_WR;
              mwr_d   = 1'b1;
            end else begin
              state_d = ST_RD;
              mrd_d   = 1'b1;
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RD, ST_WR: begin
        if (bus.MACK) begin
          // Acknowledge beats a coincident timeout.
          state_d = ST_FIN;
          done_d  = 1'b1;
          if (state_q == ST_RD) begin
            rd_re_d   = 1'b1;
            rd_word_d = word_q;
            rd_sext_d = sext_q & ~word_q;
            if (word_q) begin
              rdata_d = bus.MRDATA;
            end else if (lane_q) begin
              rdata_d = {8'h00, bus.MRDATA[15:8]};
            end else begin
              rdata_d = {8'h00, bus.MRDATA[7:0]};
            end
          end else begin
            rdata_d = rdata_q;
          end
        end else if (cnt_q == TMO_LAST) begin
          state_d  = ST_FIN;
          done_d   = 1'b1;
          tmoerr_d = 1'b1;
        end else begin
          cnt_d = cnt_q + TMO_W'(1);
          mrd_d = (state_q == ST_RD);
          mwr_d = (state_q == ST_WR);
        end
      end

      ST_FIN: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset drops strobes and pulses at once.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      word_q    <= 1'b0;
      sext_q    <= 1'b0;
      lane_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      odderr_q  <= 1'b0;
      tmoerr_q  <= 1'b0;
      maddr_q   <= 16'h0000;
      mwdata_q  <= 16'h0000;
      mbe_q     <= 2'b00;
      mrd_q     <= 1'b0;
      mwr_q     <= 1'b0;
      rdata_q   <= 16'h0000;
      rd_word_q <= 1'b0;
      rd_re_q   <= 1'b0;
      rd_sext_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      sext_q    <= sext_d;
      lane_q    <= lane_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      odderr_q  <= odderr_d;
      tmoerr_q  <= tmoerr_d;
      maddr_q   <= maddr_d;
      mwdata_q  <= mwdata_d;
      mbe_q     <= mbe_d;
      mrd_q     <= mrd_d;
      mwr_q     <= mwr_d;
      rdata_q   <= rdata_d;
      rd_word_q <= rd_word_d;
      rd_re_q   <= rd_re_d;
      rd_sext_q <= rd_sext_d;
    end
  end

  assign bus.BUSY    = busy_q;
  assign bus.DONE    = done_q;
  assign bus.ODDERR  = odderr_q;
  assign bus.TMOERR  = tmoerr_q;
  assign bus.MADDR   = maddr_q;
  assign bus.MWDATA  = mwdata_q;
  assign bus.MBE     = mbe_q;
  assign bus.MRD     = mrd_q;
  assign bus.MWR     = mwr_q;
  assign bus.RDATA   = rdata_q;
  assign bus.RD_WORD = rd_word_q;
  assign bus.RD_RE   = rd_re_q;
  assign bus.RD_SEXT = rd_sext_q;

endmodule

// File: tb/tb_memseq.sv
// Scoreboard bench for memseq: a driver issues requests and plays the memory
// bus, pushing the expected completion into a queue; a monitor pops and
// compares on every DONE. The bus-side and latency checks live in the driver.
module tb_memseq;
  localparam int TMO = 4;

  logic CLOCK;
  logic RESET_N;
  memseq_if bus();

  memseq #(.TMO_CYCLES(TMO), .TMO_W(8)) dut (
    .CLOCK   (CLOCK),
    .RESET_N (RESET_N),
    .bus     (bus.slave)
  );

  typedef struct {
    logic        odderr;
    logic        tmoerr;
    logic        rd_re;
    logic        rd_word;
    logic        rd_sext;
    logic [15:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] model_rdata = 16'h0000;

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every completion must match the oldest outstanding expectation.
  always @(negedge CLOCK) begin
    if (RESET_N && bus.DONE === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("odderr",  {31'd0, bus.ODDERR},  {31'd0, e.odderr});
        check("tmoerr",  {31'd0, bus.TMOERR},  {31'd0, e.tmoerr});
        check("rd_re",   {31'd0, bus.RD_RE},   {31'd0, e.rd_re});
        check("rd_word", {31'd0, bus.RD_WORD}, {31'd0, e.rd_word});
        check("rd_sext", {31'd0, bus.RD_SEXT}, {31'd0, e.rd_sext});
        check("rdata",   {16'd0, bus.RDATA},   {16'd0, e.rdata});
      end
    end
  end

  // One transaction: MACK is raised in strobe cycle 'delay' (0-based);
  // delay >= TMO means the memory never answers in time.
  task automatic do_req(input logic wr, input logic wd, input logic sx,
                        input logic [15:0] addr, input logic [15:0] wdata,
                        input int delay, input logic [15:0] mrdata,
                        input logic hold_req);
    exp_t        e;
    logic        odd, acked, read_ok;
    logic [15:0] exp_maddr, exp_mwdata;
    logic [1:0]  exp_mbe;
    int          exp_strobes, strobes, k;

    odd        = wd & addr[0];
    acked      = (delay < TMO);
    read_ok    = !wr && !odd && acked;
    exp_maddr  = addr & 16'hFFFE;
    exp_mbe    = wd ? 2'b11 : (addr[0] ? 2'b10 : 2'b01);
    exp_mwdata = wd ? wdata : {wdata[7:0], wdata[7:0]};
    exp_strobes = odd ? 0 : (acked ? delay + 1 : TMO);
    if (read_ok) begin
      if (wd) model_rdata = mrdata;
      else if (addr[0]) model_rdata = {8'h00, mrdata[15:8]};
      else model_rdata = {8'h00, mrdata[7:0]};
    end
    e.odderr  = odd;
    e.tmoerr  = !odd && !acked;
    e.rd_re   = read_ok;
    e.rd_word = read_ok & wd;
    e.rd_sext = read_ok & sx & !wd;
    e.rdata   = model_rdata;

    k = 0;
    @(negedge CLOCK);
    while (bus.BUSY && k < 20) begin
      @(negedge CLOCK);
      k++;
    end
    check("idle_wait", {31'd0, (k < 20)}, 32'd1);

    bus.REQ   = 1'b1;
    bus.WRITE = wr;
    bus.WORD  = wd;
    bus.SEXT  = sx;
    bus.ADDR  = addr;
    bus.WDATA = wdata;
    exp_q.push_back(e);
    @(negedge CLOCK);
    if (!hold_req) bus.REQ = 1'b0;
    bus.WDATA = $urandom();
    bus.ADDR  = $urandom();

    strobes = 0;
    while ((bus.MRD || bus.MWR) && strobes < TMO + 10) begin
      check("mrd",    {31'd0, bus.MRD}, {31'd0, !wr});
      check("mwr",    {31'd0, bus.MWR}, {31'd0, wr});
      check("maddr",  {16'd0, bus.MADDR},  {16'd0, exp_maddr});
      check("mbe",    {30'd0, bus.MBE},    {30'd0, exp_mbe});
      if (wr) check("mwdata", {16'd0, bus.MWDATA}, {16'd0, exp_mwdata});
      bus.MACK   = (strobes == delay);
      bus.MRDATA = (strobes == delay) ? mrdata : 16'(~mrdata);
      strobes++;
      @(negedge CLOCK);
    end
    bus.MACK = 1'b0;
    check("strobe_cycles", strobes, exp_strobes);
    check("done_latency", {31'd0, bus.DONE}, 32'd1);

    if (hold_req) begin
      // REQ still high through FIN: the cycle after FIN must be IDLE.
      @(negedge CLOCK);
      check("req_ignored_in_fin", {31'd0, bus.BUSY}, 32'd0);
      bus.REQ = 1'b0;
    end
  endtask

  initial begin
    bus.REQ = 1'b0; bus.WRITE = 1'b0; bus.WORD = 1'b0; bus.SEXT = 1'b0;
    bus.ADDR = 16'h0000; bus.WDATA = 16'h0000;
    bus.MACK = 1'b0; bus.MRDATA = 16'h0000;
    RESET_N = 1'b0;
    #12;
    check("rst_busy",  {31'd0, bus.BUSY}, 32'd0);
    check("rst_done",  {31'd0, bus.DONE}, 32'd0);
    check("rst_strobe", {30'd0, bus.MRD, bus.MWR}, 32'd0);
    check("rst_maddr", {16'd0, bus.MADDR}, 32'd0);
    check("rst_mwdata", {16'd0, bus.MWDATA}, 32'd0);
    check("rst_mbe",   {30'd0, bus.MBE}, 32'd0);
    check("rst_rdata", {16'd0, bus.RDATA}, 32'd0);
    check("rst_rdgate", {29'd0, bus.RD_RE, bus.RD_WORD, bus.RD_SEXT}, 32'd0);
    @(negedge CLOCK);
    RESET_N = 1'b1;

    // Directed cases
    do_req(1'b0, 1'b1, 1'b0, 16'h1000, 16'h0000, 1, 16'hBEEF, 1'b0);
    do_req(1'b0, 1'b0, 1'b1, 16'h2001, 16'h0000, 0, 16'h80AA, 1'b0);
    do_req(1'b1, 1'b0, 1'b0, 16'h3003, 16'h1234, 3, 16'h0000, 1'b0);
    do_req(1'b1, 1'b1, 1'b0, 16'h0005, 16'h5555, 0, 16'h0000, 1'b0);
    do_req(1'b0, 1'b1, 1'b0, 16'h4000, 16'h0000, 100, 16'h1111, 1'b0);
    do_req(1'b0, 1'b1, 1'b0, 16'h4002, 16'h0000, TMO - 1, 16'hC3A5, 1'b0);
    do_req(1'b0, 1'b0, 1'b0, 16'h4004, 16'h0000, 0, 16'h7F9C, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      do_req(1'($urandom()), 1'($urandom()), 1'($urandom()),
             16'($urandom()), 16'($urandom()),
             int'($urandom_range(0, TMO + 1)), 16'($urandom()), 1'b0);
    end

    // Reset pulse in the middle of a write: strobe drops, no DONE follows.
    @(negedge CLOCK);
    while (bus.BUSY) @(negedge CLOCK);
    bus.REQ = 1'b1; bus.WRITE = 1'b1; bus.WORD = 1'b0; bus.ADDR = 16'h3003;
    bus.WDATA = 16'h00AB;
    @(negedge CLOCK);
    bus.REQ = 1'b0;
    check("wr_strobe_before_rst", {31'd0, bus.MWR}, 32'd1);
    @(negedge CLOCK);
    #2 RESET_N = 1'b0;
    #1;
    check("rst_mid_mwr",  {31'd0, bus.MWR},  32'd0);
    check("rst_mid_busy", {31'd0, bus.BUSY}, 32'd0);
    check("rst_mid_done", {31'd0, bus.DONE}, 32'd0);
    model_rdata = 16'h0000;
    @(negedge CLOCK);
    RESET_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLOCK);
      check("no_done_after_rst", {31'd0, bus.DONE}, 32'd0);
    end

    // Sequencer still works after the abort.
    do_req(1'b0, 1'b1, 1'b0, 16'h5000, 16'h0000, 2, 16'h600D, 1'b0);
    repeat (3) @(negedge CLOCK);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
